// File: rtl/lsu_pkg.sv
// Shared RV32 width codes, FSM state encoding and request-decode helpers for the LSU memory controller.
// Pure declarations: no latency, no flow control.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RESP
    } state_t;

    // Stores have no unsigned variants, so LBU/LHU codes are illegal with we=1.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic [1:0] f3_align_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 2'b00;
            2'b01:   return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Load lane extract with sign/zero extension and store byte-lane merge into a read word.
// Purely combinational: zero latency, no flow control.
module lsu_align (
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merge_word
);
    import lsu_pkg::*;

    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        shifted = mem_word >> {byte_off, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = byte_off[1] ? mem_word[31:16] : mem_word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'h0, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'h0, lane_h};
            default: load_data = mem_word;
        endcase
    end

    always_comb begin
        merge_word = mem_word;
        case (funct3)
            F3_B:    merge_word[{byte_off, 3'b000} +: 8]        = store_data[7:0];
            F3_H:    merge_word[{byte_off[1], 4'b0000} +: 16]   = store_data[15:0];
            default: merge_word = store_data;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-request LSU controller to a registered word memory; LSU_MISALIGN_TRAP_EN traps misaligned accesses.
// Load resp 3 cycles after accept (RMW store 4, word store 2, error 1); req_ready only in IDLE, no queuing.
module lsu_mem_ctrl #(
    parameter int unsigned MEM_WORDS = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        d_r_en,
    output logic        d_w_en,
    output logic [31:0] d_add,
    output logic [31:0] data_in,
    input  logic [31:0] d_out
);
    import lsu_pkg::*;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [2:0]  f3_q;
    logic        we_q, err_q;
    logic        accept, oor, req_err;
    logic [1:0]  amask;
    logic [31:0] addr_fix, load_data, merge_word;

    assign accept = req_valid && req_ready;
    assign amask  = f3_align_mask(req_funct3);
    assign oor    = {2'b00, req_addr[31:2]} >= MEM_WORDS;

`ifdef LSU_MISALIGN_TRAP_EN
    assign addr_fix = req_addr;
    assign req_err  = !f3_legal(req_we, req_funct3) || oor || (|(req_addr[1:0] & amask));
`else
    assign addr_fix = {req_addr[31:2], req_addr[1:0] & ~amask};
    assign req_err  = !f3_legal(req_we, req_funct3) || oor;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nxt = ST_RESP;
                    else if (req_we && req_funct3 == F3_W)
                        state_nxt = ST_WR;
                    else
                        state_nxt = ST_RD;
                end
            end
            ST_RD:   state_nxt = ST_CAP;
            ST_CAP:  state_nxt = we_q ? ST_WR : ST_RESP;
            ST_WR:   state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Enables are gated by rst so a reset landing in RD/WR never touches memory.
    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        d_r_en     = (state == ST_RD) && !rst;
        d_w_en     = (state == ST_WR) && !rst;
        d_add      = (d_r_en || d_w_en) ? {2'b00, addr_q[31:2]} : 32'h0;
        data_in    = d_w_en ? wdata_q : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            f3_q    <= 3'b000;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= addr_fix;
            wdata_q <= req_wdata;
            rdata_q <= 32'h0;
            f3_q    <= req_funct3;
            we_q    <= req_we;
            err_q   <= req_err;
        end else if (state == ST_CAP) begin
            // Sub-word stores fold the read word into wdata_q so WR drives the merged word.
            if (we_q)
                wdata_q <= merge_word;
            else
                rdata_q <= load_data;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    lsu_align u_align (
        .funct3     (f3_q),
        .byte_off   (addr_q[1:0]),
        .mem_word   (d_out),
        .store_data (wdata_q),
        .load_data  (load_data),
        .merge_word (merge_word)
    );

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, reset/back-to-back sequences, random traffic vs a byte-array model.
// Drives and samples on the falling clock edge; a word memory model answers d_r_en/d_w_en.
module tb_lsu_mem_ctrl;

    localparam int unsigned MW = 100;

    logic        clk, rst, clr;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        d_r_en, d_w_en;
    logic [31:0] d_add, data_in, d_out;

    int n_cmp = 0;
    int n_bad = 0;
    int viol  = 0;

    logic [31:0] mem [0:MW-1];
    logic [7:0]  ref_b [0:4*MW-1];

    lsu_mem_ctrl #(.MEM_WORDS(MW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .d_r_en     (d_r_en),
        .d_w_en     (d_w_en),
        .d_add      (d_add),
        .data_in    (data_in),
        .d_out      (d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < int'(MW); i++) mem[i] <= 32'h0;
            d_out <= 32'h0;
        end else begin
            if (d_r_en && d_add < MW) d_out <= mem[d_add];
            if (d_w_en && d_add < MW) mem[d_add] <= data_in;
        end
    end

    always @(negedge clk) begin
        if (d_r_en && d_w_en) viol++;
        if (!d_r_en && !d_w_en && (d_add != 32'h0 || data_in != 32'h0)) viol++;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] idx);
        return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
    endfunction

    // Byte-addressed model: sizes, lanes and extension derived from the RV32 rules directly.
    task automatic ref_model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, output logic [31:0] xr, output logic xe,
                             output int xrd, output int xwr, output int xlat, output logic [31:0] xdin);
        int size;
        logic legal;
        logic [31:0] a, v;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        a = addr;
        xr = 32'h0; xrd = 0; xwr = 0; xdin = 32'h0;
        xe = !legal || (a / 4 >= MW);
        if (a % size != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
            xe = 1'b1;
`else
            a = a - (a % size);
`endif
        end
        if (xe) begin
            xlat = 1;
            return;
        end
        if (!we) begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_b[a+i]) << (8*i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
            xr = v; xrd = 1; xlat = 3;
        end else begin
            for (int i = 0; i < size; i++) ref_b[a+i] = 8'(wd >> (8*i));
            xwr = 1; xrd = (size < 4) ? 1 : 0; xlat = (size < 4) ? 4 : 2;
            xdin = ref_word(a / 4);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int nrd, output int nwr, output int lat,
                          output logic [31:0] din, output logic ok);
        int n;
        ok = 1'b1; rd = 32'h0; er = 1'b0; nrd = 0; nwr = 0; lat = 0; din = 32'h0;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            ok = 1'b0;
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            if (d_r_en) nrd++;
            if (d_w_en) begin
                nwr++;
                din = data_in;
            end
            if (resp_valid) break;
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) ok = 1'b0;
        else begin
            rd = resp_rdata;
            er = resp_err;
        end
    endtask

    task automatic run_check(input string nm, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic use_tbl, input logic [31:0] tr, input logic te,
                             input int trd, input int twr, input int tlat, input logic [31:0] tdin);
        logic [31:0] xr, xdin, rd, din;
        logic xe, er, ok;
        int xrd, xwr, xlat, nrd, nwr, lat;
        ref_model(we, f3, addr, wd, xr, xe, xrd, xwr, xlat, xdin);
        if (use_tbl) begin
            xr = tr; xe = te; xrd = trd; xwr = twr; xlat = tlat; xdin = tdin;
        end
        do_req(we, f3, addr, wd, rd, er, nrd, nwr, lat, din, ok);
        chk({nm, " handshake"}, 32'(ok), 32'd1);
        chk({nm, " rdata"}, rd, xr);
        chk({nm, " err"}, 32'(er), 32'(xe));
        chk({nm, " rd_en count"}, 32'(nrd), 32'(xrd));
        chk({nm, " wr_en count"}, 32'(nwr), 32'(xwr));
        chk({nm, " latency"}, 32'(lat), 32'(xlat));
        if (xwr > 0) chk({nm, " data_in"}, din, xdin);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] xr;
        logic        xe;
        int          xrd;
        int          xwr;
        int          xlat;
        logic [31:0] xdin;
    } vec_t;

    vec_t tbl [19];

    initial begin
        int n, cyc, nresp, nready;
        int resp_cyc [2];
        logic [31:0] resp_dat [2];
        logic [2:0] f3;
        logic we;
        logic [31:0] addr;

        tbl[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 0, 1, 2, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1, 0, 3, 32'h0};
        tbl[2]  = '{1'b1, 3'b010, 32'h20,  32'h80F07F01, 32'h0,        1'b0, 0, 1, 2, 32'h80F07F01};
        tbl[3]  = '{1'b0, 3'b000, 32'h23,  32'h0,        32'hFFFFFF80, 1'b0, 1, 0, 3, 32'h0};
        tbl[4]  = '{1'b0, 3'b100, 32'h23,  32'h0,        32'h00000080, 1'b0, 1, 0, 3, 32'h0};
        tbl[5]  = '{1'b0, 3'b001, 32'h22,  32'h0,        32'hFFFF80F0, 1'b0, 1, 0, 3, 32'h0};
        tbl[6]  = '{1'b0, 3'b101, 32'h20,  32'h0,        32'h00007F01, 1'b0, 1, 0, 3, 32'h0};
        tbl[7]  = '{1'b1, 3'b010, 32'h20,  32'h11223344, 32'h0,        1'b0, 0, 1, 2, 32'h11223344};
        tbl[8]  = '{1'b1, 3'b000, 32'h21,  32'h000000AA, 32'h0,        1'b0, 1, 1, 4, 32'h1122AA44};
        tbl[9]  = '{1'b0, 3'b010, 32'h20,  32'h0,        32'h1122AA44, 1'b0, 1, 0, 3, 32'h0};
        tbl[10] = '{1'b0, 3'b010, 32'h190, 32'h0,        32'h0,        1'b1, 0, 0, 1, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[11] = '{1'b0, 3'b010, 32'h12,  32'h0,        32'h0,        1'b1, 0, 0, 1, 32'h0};
        tbl[15] = '{1'b0, 3'b001, 32'h21,  32'h0,        32'h0,        1'b1, 0, 0, 1, 32'h0};
`else
        tbl[11] = '{1'b0, 3'b010, 32'h12,  32'h0,        32'hDEADBEEF, 1'b0, 1, 0, 3, 32'h0};
        tbl[15] = '{1'b0, 3'b001, 32'h21,  32'h0,        32'hFFFFAA44, 1'b0, 1, 0, 3, 32'h0};
`endif
        tbl[12] = '{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1, 0, 0, 1, 32'h0};
        tbl[13] = '{1'b1, 3'b100, 32'h10,  32'h0BADF00D, 32'h0,        1'b1, 0, 0, 1, 32'h0};
        tbl[14] = '{1'b1, 3'b001, 32'h22,  32'h00005566, 32'h0,        1'b0, 1, 1, 4, 32'h5566AA44};
        tbl[16] = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1, 0, 3, 32'h0};
        tbl[17] = '{1'b0, 3'b010, 32'h18C, 32'h0,        32'h0,        1'b0, 1, 0, 3, 32'h0};
        tbl[18] = '{1'b1, 3'b000, 32'h18F, 32'h0000007F, 32'h0,        1'b0, 1, 1, 4, 32'h7F000000};

        for (int i = 0; i < 4 * int'(MW); i++) ref_b[i] = 8'h0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h0;
        rst = 1'b1; clr = 1'b1;

        @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        chk("reset d_r_en", 32'(d_r_en), 32'd0);
        chk("reset d_w_en", 32'(d_w_en), 32'd0);
        @(negedge clk);
        rst = 1'b0; clr = 1'b0;

        for (int i = 0; i < 19; i++)
            run_check($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, 1'b1,
                      tbl[i].xr, tbl[i].xe, tbl[i].xrd, tbl[i].xwr, tbl[i].xlat, tbl[i].xdin);

        // Reset landing in WR must drop the store and its response.
        run_check("pre-reset SW", 1'b1, 3'b010, 32'h08, 32'h12345678, 1'b0, 32'h0, 1'b0, 0, 0, 0, 32'h0);
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h08; req_wdata = 32'h5; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst-in-WR accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst-in-WR reached WR", 32'(d_w_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst-in-WR d_w_en gated", 32'(d_w_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nresp = 0;
        for (int i = 0; i < 5; i++) begin
            if (resp_valid) nresp++;
            @(negedge clk);
        end
        chk("rst-in-WR no response", 32'(nresp), 32'd0);
        chk("rst-in-WR ready after", 32'(req_ready), 32'd1);
        run_check("post-reset LW", 1'b0, 3'b010, 32'h08, 32'h0, 1'b1, 32'h12345678, 1'b0, 1, 0, 3, 32'h0);

        // Two loads with req_valid held high: second accepted only in the IDLE after the first RESP.
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_addr = 32'h20;
        cyc = 1; nresp = 0; nready = 0;
        resp_cyc[0] = 0; resp_cyc[1] = 0; resp_dat[0] = 32'h0; resp_dat[1] = 32'h0;
        while (cyc <= 12) begin
            if (req_ready) nready++;
            if (resp_valid) begin
                resp_cyc[nresp] = cyc;
                resp_dat[nresp] = resp_rdata;
                nresp++;
                if (nresp == 2) begin
                    req_valid = 1'b0;
                    break;
                end
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        chk("b2b response count", 32'(nresp), 32'd2);
        chk("b2b first resp cycle", 32'(resp_cyc[0]), 32'd3);
        chk("b2b second resp cycle", 32'(resp_cyc[1]), 32'd7);
        chk("b2b ready cycles between", 32'(nready), 32'd1);
        chk("b2b first data", resp_dat[0], ref_word(32'h10 / 4));
        chk("b2b second data", resp_dat[1], ref_word(32'h20 / 4));

        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1, 2: f3 = 3'b000;
                3, 4, 5: f3 = 3'b001;
                6, 7:    f3 = 3'b010;
                8:       f3 = we ? 3'b010 : 3'($urandom_range(4, 5));
                default: f3 = 3'($urandom_range(3, 7));
            endcase
            if ($urandom_range(0, 15) == 0) addr = 32'h8000_0000 | 32'($urandom);
            else addr = 32'($urandom_range(0, 4 * MW + 15));
            run_check($sformatf("rnd%0d", i), we, f3, addr, 32'($urandom), 1'b0,
                      32'h0, 1'b0, 0, 0, 0, 32'h0);
        end

        @(negedge clk);
        chk("enable exclusivity and idle zeroing", 32'(viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
